// File: rtl/io_init_sequencer.sv
// io_init_sequencer
// Plays a fixed power-on write table into the GB IO register bus.
// It also arbitrates that bus between the CPU and the table player.
// Addresses and data are GB-native because the block sits after the MegaDuck swizzle.
// While the table runs, the CPU is stalled and its strobes are blocked.
// At all other times the CPU passes straight through to the IO decode.
module io_init_sequencer #(
    parameter bit AUTO_START = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic        megaduck,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic        cpu_wait,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_do,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic        busy,
    output logic        done,
    output logic        seq_mode
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [2:0] ST_RESET = AUTO_START ? ST_DRAIN : ST_IDLE;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'd7;

    logic [2:0]  state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [3:0]  gap_reg, gap_next;
    logic        seq_mode_reg, seq_mode_next;
    // Remembers a restart that arrived between ce ticks, so it takes effect on the next tick.
    logic        restart_reg, restart_next;

    logic [15:0] tbl_addr;
    logic [7:0]  tbl_data;

    // Power-on table lookup.
    // NR52 comes first because the sound registers ignore writes while the APU is powered down.
    always_comb begin
        tbl_addr = 16'hFF26;
        tbl_data = 8'h80;
        case (idx_reg)
            3'd0: begin tbl_addr = 16'hFF26; tbl_data = 8'h80; end
            3'd1: begin tbl_addr = 16'hFF25; tbl_data = 8'hF3; end
            3'd2: begin tbl_addr = 16'hFF24; tbl_data = 8'h77; end
            3'd3: begin tbl_addr = 16'hFF40; tbl_data = 8'h91; end
            3'd4: begin tbl_addr = 16'hFF47; tbl_data = 8'hFC; end
            3'd5: begin tbl_addr = 16'hFF48; tbl_data = 8'hFF; end
            3'd6: begin tbl_addr = 16'hFF49; tbl_data = 8'hFF; end
            default: begin tbl_addr = 16'hFF42; tbl_data = 8'h00; end
        endcase
    end

    // Next-state logic.
    // start is honoured on any clk_sys edge.
    // All other progress waits for ce, except leaving FIN.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        gap_next      = gap_reg;
        seq_mode_next = seq_mode_reg;
        restart_next  = restart_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_DRAIN;
                    idx_next      = 3'd0;
                    seq_mode_next = megaduck;
                end
            end
            ST_DRAIN: begin
                // Nothing has been written yet.
                // A restart here only re-latches the mode and keeps waiting for the CPU access to finish.
                if (start) begin
                    idx_next      = 3'd0;
                    seq_mode_next = megaduck;
                end
                if (ce && !cpu_wr && !cpu_rd) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE, ST_GAP: begin
                if (start) begin
                    seq_mode_next = megaduck;
                end
                if (ce) begin
                    if (start || restart_reg) begin
                        state_next   = ST_WRITE;
                        idx_next     = 3'd0;
                        restart_next = 1'b0;
                    end else if (state_reg == ST_WRITE) begin
                        state_next = ST_GAP;
                        gap_next   = GAP_LOAD;
                    end else if (gap_reg != 4'd0) begin
                        gap_next = gap_reg - 4'd1;
                    end else if (idx_reg == IDX_LAST) begin
                        state_next = ST_FIN;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = ST_WRITE;
                    end
                end else if (start) begin
                    idx_next     = 3'd0;
                    restart_next = 1'b1;
                end
            end
            ST_FIN: begin
                if (start) begin
                    state_next    = ST_DRAIN;
                    idx_next      = 3'd0;
                    seq_mode_next = megaduck;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_RESET;
            idx_reg      <= 3'd0;
            gap_reg      <= 4'd0;
            seq_mode_reg <= 1'b0;
            restart_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            gap_reg      <= gap_next;
            seq_mode_reg <= seq_mode_next;
            restart_reg  <= restart_next;
        end
    end

    // Bus mux.
    // The CPU drives the bus in IDLE and DRAIN, so an in-flight access can complete.
    // The table drives the bus from WRITE through FIN, so CPU strobes are dropped there.
    always_comb begin
        bus_addr = cpu_addr;
        bus_do   = cpu_do;
        bus_wr   = cpu_wr;
        bus_rd   = cpu_rd;
        if (state_reg == ST_WRITE || state_reg == ST_GAP || state_reg == ST_FIN) begin
            bus_addr = tbl_addr;
            bus_do   = tbl_data;
            bus_wr   = (state_reg == ST_WRITE);
            bus_rd   = 1'b0;
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign cpu_wait = busy;
    assign done     = (state_reg == ST_FIN);
    assign seq_mode = seq_mode_reg;

endmodule
